// File: rtl/piezo_rx_burst_detector.sv
// Piezo receive qualifier: synchronise and blank the comparator input, qualify
// bursts by edge count in a window, and queue the first-edge PTP timestamp.
module piezo_rx_burst_detector #(
    parameter int TS_WIDTH     = 32,
    parameter int MIN_EDGES    = 4,
    parameter int WINDOW       = 64,
    parameter int BLANK_CYCLES = 256,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        iCLK,
    input  logic                        iRESETn,
    input  logic                        iPIEZO_IN,
    input  logic                        iTX_ENABLE,
    input  logic [TS_WIDTH-1:0]         iTIME,
    output logic [TS_WIDTH-1:0]         oTS_DATA,
    output logic                        oTS_VALID,
    input  logic                        iTS_READY,
    output logic [$clog2(FIFO_DEPTH):0] oLEVEL,
    output logic                        oOVERFLOW,
    input  logic                        iCLR_OVERFLOW,
    output logic                        oBUSY
);
    localparam int BW = $clog2(BLANK_CYCLES);
    localparam int WW = $clog2(WINDOW);
    localparam int EW = $clog2(MIN_EDGES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
    localparam logic [EW-1:0] EDGES_REQ  = EW'(MIN_EDGES);
    localparam logic [AW:0]   FULL_LVL   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_BLANK,
        S_ARMED,
        S_QUALIFY,
        S_HOLDOFF
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                r_s1, r_s2, r_s3;
    logic [BW-1:0]       r_blank_cnt;
    logic [WW-1:0]       r_win_cnt;
    logic [EW-1:0]       r_edge_cnt;
    logic [TS_WIDTH-1:0] r_ts_hold;
    logic [TS_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wptr, r_rptr;
    logic [AW:0]         r_count;
    logic                r_overflow;

    logic w_edge, w_hit, w_win_end, w_blank_end;
    logic w_push, w_pop, w_full, w_wr, w_drop;

    always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= iPIEZO_IN;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge      = r_s2 & ~r_s3;
    assign w_hit       = (r_edge_cnt + EW'(w_edge)) == EDGES_REQ;
    assign w_win_end   = r_win_cnt == WIN_LAST;
    assign w_blank_end = r_blank_cnt == BLANK_LAST;

    always_ff @(posedge iCLK) begin
        if (!iRESETn) r_state <= S_BLANK;
        else          r_state <= w_next;
    end

    // Transmit enable overrides every transition, including a qualifying edge.
    always_comb begin
        w_next = r_state;
        if (iTX_ENABLE) begin
            w_next = S_BLANK;
        end else begin
            unique case (r_state)
                S_BLANK:   if (w_blank_end) w_next = S_ARMED;
                S_ARMED:   if (w_edge) w_next = S_QUALIFY;
                S_QUALIFY: begin
                    if (w_hit)          w_next = S_HOLDOFF;
                    else if (w_win_end) w_next = S_ARMED;
                end
                S_HOLDOFF: if (w_win_end) w_next = S_ARMED;
                default:   w_next = S_BLANK;
            endcase
        end
    end

    always_comb begin
        w_push = (r_state == S_QUALIFY) && !iTX_ENABLE && w_hit;
        oBUSY  = (r_state == S_QUALIFY) || (r_state == S_HOLDOFF);
    end

    always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
            r_blank_cnt <= '0;
            r_win_cnt   <= '0;
            r_edge_cnt  <= '0;
            r_ts_hold   <= '0;
        end else begin
            if (iTX_ENABLE || r_state != S_BLANK) r_blank_cnt <= '0;
            else                                  r_blank_cnt <= r_blank_cnt + 1'b1;
            if (r_state == S_ARMED && w_edge) begin
                r_ts_hold  <= iTIME;
                r_edge_cnt <= EW'(1);
                r_win_cnt  <= '0;
            end else if (r_state == S_QUALIFY) begin
                r_edge_cnt <= r_edge_cnt + EW'(w_edge);
                if (w_hit) r_win_cnt <= '0;
                else       r_win_cnt <= r_win_cnt + 1'b1;
            end else if (r_state == S_HOLDOFF) begin
                r_win_cnt <= r_win_cnt + 1'b1;
            end
        end
    end

    // A push into a full FIFO is only accepted when the head leaves this cycle.
    assign w_full = r_count == FULL_LVL;
    assign w_pop  = (r_count != '0) && iTS_READY;
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= r_ts_hold;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (AW + 1)'(w_wr) - (AW + 1)'(w_pop);
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRESETn)          r_overflow <= 1'b0;
        else if (w_drop)       r_overflow <= 1'b1;
        else if (iCLR_OVERFLOW) r_overflow <= 1'b0;
    end

    assign oTS_DATA  = r_mem[r_rptr];
    assign oTS_VALID = r_count != '0;
    assign oLEVEL    = r_count;
    assign oOVERFLOW = r_overflow;

endmodule

// File: tb/tb_piezo_rx_burst_detector.sv
// Bench for piezo_rx_burst_detector: directed bursts, expected timestamps
// queued at stimulus time and compared by a monitor whenever the DUT pops.
module tb_piezo_rx_burst_detector;
    logic        iCLK          = 1'b0;
    logic        iRESETn       = 1'b0;
    logic        iPIEZO_IN     = 1'b0;
    logic        iTX_ENABLE    = 1'b0;
    logic        iTS_READY     = 1'b0;
    logic        iCLR_OVERFLOW = 1'b0;
    logic [31:0] iTIME;
    logic [31:0] oTS_DATA;
    logic        oTS_VALID;
    logic [2:0]  oLEVEL;
    logic        oOVERFLOW;
    logic        oBUSY;
    logic [31:0] cyc = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb[$];

    piezo_rx_burst_detector dut (
        .iCLK(iCLK),
        .iRESETn(iRESETn),
        .iPIEZO_IN(iPIEZO_IN),
        .iTX_ENABLE(iTX_ENABLE),
        .iTIME(iTIME),
        .oTS_DATA(oTS_DATA),
        .oTS_VALID(oTS_VALID),
        .iTS_READY(iTS_READY),
        .oLEVEL(oLEVEL),
        .oOVERFLOW(oOVERFLOW),
        .iCLR_OVERFLOW(iCLR_OVERFLOW),
        .oBUSY(oBUSY)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 32'd1;
    assign iTIME = 32'd1000 + cyc;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge iCLK) begin
        if (iRESETn && oTS_VALID && iTS_READY) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got %0d, expected no entry",
                         oTS_DATA);
            end else begin
                chk("pop_data", oTS_DATA, sb.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic wait_time(input logic [31:0] target);
        int k = 0;
        while (iTIME != target && k < 20000) begin
            tick(1);
            k++;
        end
        if (iTIME != target) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_time: got %0d, expected %0d", iTIME, target);
        end
    endtask

    task automatic drive(input int mode, input logic v);
        case (mode)
            1: iTX_ENABLE    = v;
            2: iTS_READY     = v;
            3: iCLR_OVERFLOW = v;
            default: ;
        endcase
    endtask

    // Rising edges 8 cycles apart; mode drives a side signal in the cycle
    // where the last edge pulse is seen by the qualifier.
    task automatic burst(input int n, input int mode, output logic [31:0] ts);
        ts = iTIME + 32'd2;
        for (int i = 0; i < n; i++) begin
            iPIEZO_IN = 1'b1;
            if (i == n - 1 && mode != 0) begin
                tick(2);
                drive(mode, 1'b1);
                tick(1);
                drive(mode, 1'b0);
                tick(1);
            end else begin
                tick(4);
            end
            iPIEZO_IN = 1'b0;
            tick(4);
        end
    endtask

    task automatic pop1();
        iTS_READY = 1'b1;
        tick(1);
        iTS_READY = 1'b0;
    endtask

    initial begin
        logic [31:0] t0;
        logic [31:0] ts;

        tick(3);
        chk("rst_valid", oTS_VALID, 0);
        chk("rst_level", oLEVEL, 0);
        chk("rst_ovf", oOVERFLOW, 0);
        chk("rst_busy", oBUSY, 0);
        chk("rst_data", oTS_DATA, 0);
        iRESETn = 1'b1;
        tick(300);

        wait_time(32'd4998);
        sb.push_back(32'd5000);
        burst(4, 0, ts);
        chk("basic_valid", oTS_VALID, 1);
        chk("basic_level", oLEVEL, 1);
        chk("basic_head", oTS_DATA, 32'd5000);
        chk("basic_holdoff_busy", oBUSY, 1);
        pop1();
        chk("basic_pop_valid", oTS_VALID, 0);
        chk("basic_pop_level", oLEVEL, 0);
        tick(70);

        t0 = iTIME;
        burst(3, 0, ts);
        wait_time(t0 + 32'd65);
        iPIEZO_IN = 1'b1;
        tick(2);
        chk("weak_armed_busy", oBUSY, 0);
        chk("weak_no_push", oLEVEL, 0);
        tick(1);
        chk("weak_restart_busy", oBUSY, 1);
        tick(1);
        iPIEZO_IN = 1'b0;
        tick(4);
        sb.push_back(t0 + 32'd67);
        burst(3, 0, ts);
        chk("weak_level", oLEVEL, 1);
        chk("weak_head", oTS_DATA, t0 + 32'd67);
        pop1();
        tick(70);

        iTX_ENABLE = 1'b1;
        tick(2);
        burst(4, 0, ts);
        chk("blank_tx_busy", oBUSY, 0);
        iTX_ENABLE = 1'b0;
        t0 = iTIME;
        burst(4, 0, ts);
        wait_time(t0 + 32'd252);
        iPIEZO_IN = 1'b1;
        tick(1);
        iPIEZO_IN = 1'b0;
        tick(1);
        chk("blank_level", oLEVEL, 0);
        chk("blank_busy", oBUSY, 0);
        sb.push_back(t0 + 32'd256);
        burst(4, 0, ts);
        chk("blank_end_level", oLEVEL, 1);
        chk("blank_end_head", oTS_DATA, t0 + 32'd256);
        pop1();
        chk("blank_pop_valid", oTS_VALID, 0);
        tick(70);

        burst(4, 1, ts);
        chk("abort_busy", oBUSY, 0);
        chk("abort_level", oLEVEL, 0);
        tick(20);
        burst(4, 0, ts);
        chk("abort_blank_level", oLEVEL, 0);
        tick(260);

        for (int i = 0; i < 5; i++) begin
            burst(4, 0, ts);
            if (i < 4) sb.push_back(ts);
            tick(70);
        end
        chk("full_level", oLEVEL, 4);
        chk("full_ovf", oOVERFLOW, 1);
        iCLR_OVERFLOW = 1'b1;
        tick(1);
        iCLR_OVERFLOW = 1'b0;
        chk("ovf_clear", oOVERFLOW, 0);
        burst(4, 2, ts);
        sb.push_back(ts);
        chk("full_pushpop_level", oLEVEL, 4);
        chk("full_pushpop_ovf", oOVERFLOW, 0);
        tick(70);
        burst(4, 3, ts);
        chk("ovf_set_wins", oOVERFLOW, 1);
        chk("ovf_drop_level", oLEVEL, 4);
        iCLR_OVERFLOW = 1'b1;
        tick(1);
        iCLR_OVERFLOW = 1'b0;
        chk("ovf_clear2", oOVERFLOW, 0);
        iTS_READY = 1'b1;
        tick(4);
        iTS_READY = 1'b0;
        chk("drain_valid", oTS_VALID, 0);
        chk("drain_level", oLEVEL, 0);
        tick(70);

        burst(4, 0, ts);
        chk("pre_rst_level", oLEVEL, 1);
        tick(70);
        burst(2, 0, ts);
        chk("pre_rst_busy", oBUSY, 1);
        iRESETn = 1'b0;
        sb.delete();
        tick(1);
        chk("mid_rst_valid", oTS_VALID, 0);
        chk("mid_rst_level", oLEVEL, 0);
        chk("mid_rst_data", oTS_DATA, 0);
        chk("mid_rst_ovf", oOVERFLOW, 0);
        chk("mid_rst_busy", oBUSY, 0);
        iRESETn = 1'b1;
        burst(2, 0, ts);
        chk("post_rst_level", oLEVEL, 0);
        chk("post_rst_busy", oBUSY, 0);
        tick(300);

        burst(4, 0, ts);
        sb.push_back(ts);
        chk("final_level", oLEVEL, 1);
        pop1();
        chk("final_valid", oTS_VALID, 0);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/piezo_rx_burst_detector.md
# piezo_rx_burst_detector

Receive-side qualifier for the ultrasonic piezo ranging path. It synchronises the asynchronous piezo comparator input and blanks it during and after our own transmit burst. It qualifies a received burst by counting rising edges inside a window and timestamps the first edge of each valid burst with the PTP time base. Qualified timestamps are queued in a small FWFT FIFO, which the rtc / ptp_piezo_interface register logic reads. The block sits between the piezo input pin and those consumers.

## Interface
Parameters:
- TS_WIDTH, 32: width of time base and timestamps.
- MIN_EDGES, 4: rising edges needed to qualify a burst (≥2).
- WINDOW, 64: qualification window in iCLK cycles, counted from the first edge.
- BLANK_CYCLES, 256: blanking length after iTX_ENABLE falls.
- FIFO_DEPTH, 4: timestamp FIFO entries (power of 2).

Ports:
- iCLK  in  1  system clock.
- iRESETn  in  1  reset, synchronous, active-low.
- iPIEZO_IN  in  1  asynchronous comparator output.
- iTX_ENABLE  in  1  piezo transmit enable, synchronous to iCLK.
- iTIME  in  TS_WIDTH  free-running PTP time, synchronous.
- oTS_DATA  out  TS_WIDTH  FIFO head timestamp; reset 0.
- oTS_VALID  out  1  FIFO non-empty; reset 0.
- iTS_READY  in  1  pop request, effective when oTS_VALID=1.
- oLEVEL  out  clog2(FIFO_DEPTH)+1  FIFO occupancy; reset 0.
- oOVERFLOW  out  1  sticky, set when a qualified burst is dropped because the FIFO is full; reset 0.
- iCLR_OVERFLOW  in  1  clears oOVERFLOW.
- oBUSY  out  1  high in QUALIFY or HOLDOFF; reset 0.

## Operation
- Input path:
  - iPIEZO_IN passes through 2-FF synchroniser s1→s2, plus delay register s3.
  - Edge pulse: e = s2 & ~s3.
  - All synchroniser registers reset to 0.
- State machine. Reset state is BLANK with the blank counter at 0.
  - BLANK:
    - Blank counter clears every cycle iTX_ENABLE=1 and increments while iTX_ENABLE=0.
    - Counter reaching BLANK_CYCLES-1 with iTX_ENABLE=0 → ARMED.
    - Edges are ignored.
  - ARMED:
    - On e: latch iTIME into ts_hold, set edge_cnt=1, win_cnt=0 → QUALIFY.
  - QUALIFY:
    - win_cnt increments each cycle.
    - Each e increments edge_cnt.
    - When edge_cnt+e reaches MIN_EDGES: push ts_hold → HOLDOFF.
    - Otherwise, when win_cnt reaches WINDOW-1: discard → ARMED.
  - HOLDOFF:
    - Lasts WINDOW cycles, reusing win_cnt cleared on entry; edges are ignored.
    - Then → ARMED.
  - iTX_ENABLE=1 in any state other than BLANK:
    - Next state is BLANK with the blank counter at 0.
    - Any in-progress qualification is aborted with no push.
    - This takes priority over all other transitions in the same cycle, including a qualifying edge.
- Timestamp semantics:
  - Timestamp = iTIME in the cycle e is first high in ARMED.
  - This is 2 iCLK cycles (synchroniser latency) plus up to 1 cycle of sampling uncertainty after the pin edge.
  - Consumers subtract 2.
- FIFO:
  - First-word fall-through, FIFO_DEPTH entries.
  - Pop when oTS_VALID & iTS_READY.
  - Push when full:
    - Without a simultaneous pop: entry dropped, oOVERFLOW set.
    - With a simultaneous pop: push accepted, level unchanged.
  - Push and pop on a non-empty FIFO in the same cycle: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- oOVERFLOW:
  - iCLR_OVERFLOW clears it.
  - A set event in the same cycle as a clear wins (flag stays 1).
- Counters saturate never. Widths are sized to hold max value: clog2(BLANK_CYCLES), clog2(WINDOW), clog2(MIN_EDGES+1).

## Timing
- Pin rising edge sampled by s1 at clock k → e high in cycle k+2.
- Push occurs on the clock ending the qualifying cycle → oTS_VALID=1 and oLEVEL updated in the following cycle.
- Pop takes effect at the clock edge. The next head or oTS_VALID=0 is visible the next cycle.
- After iTX_ENABLE falls at cycle t, the first accepted edge is at cycle ≥ t+BLANK_CYCLES.
- iRESETn low at any clock returns all state, counters, the FIFO, and outputs to reset values at that edge. In-flight bursts are lost.

## Test plan
- Basic burst: defaults, after blanking iTIME=1000+cycle, pin toggles 4 rising edges 8 cycles apart, first e at iTIME=5000 → one entry 5000, oTS_VALID=1, oLEVEL=1; pop → oTS_VALID=0.
- Weak burst: 3 edges within 64 cycles, then silence → no push, state returns ARMED. A 4th edge at win_cnt=64 starts a new qualification with its own timestamp.
- Blanking: edges during iTX_ENABLE=1 and during the 255 cycles after its fall → nothing pushed; burst starting at cycle 256 after fall → pushed.
- TX abort: iTX_ENABLE rises in the same cycle as the 4th edge → no push, state BLANK.
- FIFO full/overflow: 5 bursts with no reads → oLEVEL=4, oOVERFLOW=1, heads pop in order of first 4. Full plus simultaneous pop and push → accepted, level stays 4. Overflow with simultaneous iCLR_OVERFLOW → flag stays 1.
- Reset mid-QUALIFY after 2 edges → all outputs 0, state BLANK, FIFO empty, no entry pushed.
